fir_seq_host: RTL and testbench

- Initiator for the FIR filter's command interface. Operation codes: 01 load sample, 10 run, 11 read result.
- Per job, it takes SIGNAL_LEN samples from a valid/ready input stream and writes them into the filter.
- It then issues run until the filter raises done, and reads all SIGNAL_LEN results back.
- Results leave on a valid/ready output stream. Sits between the sample DMA/test source and the filter instance.

---
 rtl/fir_pkg.sv | 26 ++
 rtl/fir_out_skid.sv | 30 +++
 rtl/fir_seq_host.sv | 178 +++++++++++++++++
 tb/tb_fir_seq_host.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types for the FIR filter command interface and its host sequencer.
package fir_pkg;

    localparam int unsigned FIR_DW = 32;

    // Filter command encoding; the filter itself decodes the same type.
    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LOAD = 2'b01,
        OP_RUN  = 2'b10,
        OP_READ = 2'b11
    } op_t;

    // Host sequencer states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        LOAD   = 3'd2,
        RUN    = 3'd3,
        RDREQ  = 3'd4,
        RDWAIT = 3'd5,
        OUT    = 3'd6,
        FIN    = 3'd7
    } state_t;

endpackage

// File: rtl/fir_out_skid.sv
// One-entry result holding register: data and valid stay put until the sink takes them.
module fir_out_skid
    import fir_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [FIR_DW-1:0] load_data,
    output logic [FIR_DW-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              taken_c
);

    assign taken_c = out_valid & out_ready;

    // Capture a new result or drop valid once the sink has accepted it.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (taken_c) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fir_seq_host.sv
// Host sequencer for the FIR filter: loads a job of samples, runs the filter,
// and streams every result back out through a valid/ready port.
module fir_seq_host
    import fir_pkg::*;
#(
    parameter int unsigned SIGNAL_LEN = 1000,
    parameter int unsigned COEF_LEN   = 100,
    parameter int unsigned TIMEOUT    = SIGNAL_LEN * (COEF_LEN + 1) + 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              job_done,
    output logic              error,
    input  logic [FIR_DW-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [FIR_DW-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              f_reset,
    output logic [FIR_DW-1:0] f_addr,
    output logic [FIR_DW-1:0] f_x,
    output logic [1:0]        f_op,
    input  logic [FIR_DW-1:0] f_y,
    input  logic              f_done
);

    localparam int unsigned CW        = $clog2(SIGNAL_LEN) + 1;
    localparam logic [CW-1:0] LAST    = CW'(SIGNAL_LEN - 1);
    localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT - 1);

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [CW-1:0] k;
    logic [CW-1:0] k_n;
    logic [31:0]   wdog;
    logic [31:0]   wdog_n;
    logic          error_n;
    logic          skid_load;
    logic          out_taken;
    op_t           op_c;

    // Result holding register toward the sink.
    fir_out_skid u_skid (
        .clk       (clk),
        .reset     (reset),
        .load      (skid_load),
        .load_data (f_y),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .taken_c   (out_taken)
    );

    // State, counters and the sticky watchdog flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            k     <= '0;
            wdog  <= '0;
            error <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            k     <= k_n;
            wdog  <= wdog_n;
            error <= error_n;
        end
    end

    // Next-state and counter update logic.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        k_n       = k;
        wdog_n    = wdog;
        error_n   = error;
        skid_load = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = CLR;
                    error_n = 1'b0;
                    cnt_n   = '0;
                end
            end
            CLR: begin
                state_n = LOAD;
            end
            LOAD: begin
                if (in_valid) begin
                    if (cnt == LAST) begin
                        cnt_n   = '0;
                        wdog_n  = '0;
                        state_n = RUN;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            RUN: begin
                if (f_done) begin
                    k_n     = '0;
                    state_n = RDREQ;
                end else if (wdog == WDOG_LAST) begin
                    error_n = 1'b1;
                    state_n = IDLE;
                end else begin
                    wdog_n = wdog + 32'd1;
                end
            end
            RDREQ: begin
                state_n = RDWAIT;
            end
            RDWAIT: begin
                // Filter registers y, so it is valid the cycle after the read op.
                skid_load = 1'b1;
                state_n   = OUT;
            end
            OUT: begin
                if (out_taken) begin
                    if (k == LAST) begin
                        state_n = FIN;
                    end else begin
                        k_n     = k + CW'(1);
                        state_n = RDREQ;
                    end
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Filter command decode; forced to NOP while reset clears the filter.
    always_comb begin
        op_c   = OP_NOP;
        f_addr = '0;
        f_x    = '0;
        if (!reset) begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        op_c   = OP_LOAD;
                        f_addr = FIR_DW'(cnt);
                        f_x    = in_data;
                    end
                end
                RUN: begin
                    op_c = OP_RUN;
                end
                RDREQ: begin
                    op_c   = OP_READ;
                    f_addr = FIR_DW'(k);
                end
                default: begin
                    op_c = OP_NOP;
                end
            endcase
        end
    end

    assign f_op     = op_c;
    assign f_reset  = reset | (state == CLR);
    assign busy     = (state != IDLE);
    assign job_done = (state == FIN) & ~reset;
    assign in_ready = (state == LOAD) & ~reset;

endmodule

// File: tb/tb_fir_seq_host.sv
// Self-checking bench for fir_seq_host with a small behavioural filter model.
module tb_fir_seq_host;

    localparam int unsigned SL      = 4;
    localparam int unsigned CL      = 3;
    localparam int unsigned TO      = 20;
    localparam int unsigned RUN_LAT = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic        job_done;
    logic        error;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        f_reset;
    logic [31:0] f_addr;
    logic [31:0] f_x;
    logic [1:0]  f_op;
    logic [31:0] f_y = '0;
    logic        f_done = 1'b0;

    fir_seq_host #(.SIGNAL_LEN(SL), .COEF_LEN(CL), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .job_done  (job_done),
        .error     (error),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f_reset   (f_reset),
        .f_addr    (f_addr),
        .f_x       (f_x),
        .f_op      (f_op),
        .f_y       (f_y),
        .f_done    (f_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endfunction

    // Behavioural filter: coefs {1,2,3}, done after RUN_LAT run cycles, registered y.
    logic [31:0] fx [SL];
    int          run_cnt = 0;
    logic        never_done = 1'b0;

    function automatic logic [31:0] model_y(input int n);
        logic [31:0] acc;
        acc = '0;
        for (int j = 0; j < int'(CL); j++)
            if (n >= j) acc = acc + 32'(j + 1) * fx[n - j];
        return acc;
    endfunction

    always @(posedge clk) begin
        if (f_reset) begin
            for (int i = 0; i < int'(SL); i++) fx[i] <= '0;
            run_cnt <= 0;
            f_done  <= 1'b0;
            f_y     <= '0;
        end else begin
            case (f_op)
                2'b01: if (f_addr < SL) fx[f_addr[1:0]] <= f_x;
                2'b10: begin
                    run_cnt <= run_cnt + 1;
                    if (run_cnt >= int'(RUN_LAT) - 1 && !never_done) f_done <= 1'b1;
                end
                2'b11: f_y <= model_y(int'(f_addr[1:0]));
                default: ;
            endcase
        end
    end

    // Scoreboard and protocol monitor, sampled on the falling edge.
    logic [31:0] exp_q [$];
    int          clr_cnt = 0, done_cnt = 0, wr_cnt = 0, wr_next = 0, rd_next = 0;
    int          run_cycles = 0, nacc = 0;
    logic        pv = 1'b0, pr = 1'b0;
    logic [31:0] pd = '0;
    logic [31:0] e;

    always @(negedge clk) begin
        if (!reset) begin
            if (f_reset) begin
                clr_cnt++;
                wr_next = 0;
                rd_next = 0;
                run_cycles = 0;
            end
            if (f_op == 2'b01) begin
                check("wr_addr", f_addr, 32'(wr_next));
                check("wr_in_valid", 32'(in_valid), 32'd1);
                wr_next++;
                wr_cnt++;
            end
            if (f_op == 2'b10) run_cycles++;
            if (f_op == 2'b11) begin
                check("rd_addr", f_addr, 32'(rd_next));
                check("rd_while_pending", 32'(out_valid), 32'd0);
                rd_next++;
            end
            if (job_done) done_cnt++;
            if (pv && !pr) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", out_data, pd);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL out_extra: got %0h required no output", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e);
                end
                nacc++;
            end
            pv = out_valid;
            pr = out_ready;
            pd = out_data;
        end else begin
            pv = 1'b0;
        end
    end

    typedef struct packed {
        logic [SL-1:0][31:0] x;
        logic [SL-1:0][31:0] y;
    } vec_t;

    vec_t vecs [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_samples(input vec_t v, input bit toggle, input bit poke, output int cyc);
        int idx;
        bit acc;
        idx = 0;
        cyc = 0;
        while (idx < int'(SL) && cyc < 200) begin
            in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            in_data  = in_valid ? v.x[idx] : 32'hDEAD_0000 + 32'(cyc);
            start    = (poke && cyc == 2);
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        if (idx < int'(SL)) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got %0d samples required %0d", idx, SL);
        end
    endtask

    task automatic sink(input int target, input int base, input bit stall, input bit poke);
        int cyc;
        bit stalled;
        bit poked;
        cyc = 0;
        stalled = 0;
        poked = 0;
        out_ready = 1'b1;
        while (nacc < target && cyc < 400) begin
            if (stall && !stalled && out_valid && nacc == base + 1) begin
                out_ready = 1'b0;
                repeat (10) tick();
                out_ready = 1'b1;
                stalled = 1;
            end else if (poke && !poked && out_valid) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                poked = 1;
            end else begin
                tick();
            end
            cyc++;
        end
        if (nacc < target) begin
            tests++;
            fails++;
            $display("FAIL sink_timeout: got %0d results required %0d", nacc - base, target - base);
        end
    endtask

    task automatic wait_idle(input string name);
        int cyc;
        cyc = 0;
        while (busy && cyc < 100) begin
            tick();
            cyc++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic run_job(input int r, input bit toggle, input bit stall, input bit poke, input bit chk_err);
        int d0, c0, w0, base, lc;
        d0 = done_cnt;
        c0 = clr_cnt;
        w0 = wr_cnt;
        base = nacc;
        for (int i = 0; i < int'(SL); i++) exp_q.push_back(vecs[r].y[i]);
        pulse_start();
        if (chk_err) check("err_cleared", 32'(error), 32'd0);
        fork
            send_samples(vecs[r], toggle, poke, lc);
            sink(base + int'(SL), base, stall, poke);
        join
        if (!toggle && !poke) check("load_cycles", 32'(lc), 32'(SL + 1));
        wait_idle("job_idle");
        check("job_done_count", 32'(done_cnt - d0), 32'd1);
        check("clr_count", 32'(clr_cnt - c0), 32'd1);
        check("write_count", 32'(wr_cnt - w0), 32'(SL));
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        check("job_error", 32'(error), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int d0;
        int cyc;

        vecs[0].x = {32'd4, 32'd3, 32'd2, 32'd1};
        vecs[0].y = {32'd16, 32'd10, 32'd4, 32'd1};
        vecs[1].x = {32'd1, 32'd7, 32'd0, 32'd5};
        vecs[1].y = {32'd15, 32'd22, 32'd10, 32'd5};
        vecs[2].x = {32'd40, 32'd30, 32'd20, 32'd10};
        vecs[2].y = {32'd160, 32'd100, 32'd40, 32'd10};
        vecs[3].x = {32'd9, 32'd0, 32'd0, 32'd0};
        vecs[3].y = {32'd9, 32'd0, 32'd0, 32'd0};

        // Reset state.
        reset = 1'b1;
        repeat (3) tick();
        check("rst_f_reset", 32'(f_reset), 32'd1);
        check("rst_f_op", 32'(f_op), 32'd0);
        reset = 1'b0;
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_job_done", 32'(job_done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_f_addr", f_addr, 32'd0);
        check("rst_f_x", f_x, 32'd0);
        check("idle_f_reset", 32'(f_reset), 32'd0);

        // Table-driven jobs: plain, toggled valid, stalled sink, start pokes.
        for (int r = 0; r < 4; r++)
            run_job(r, r == 1, r == 2, r == 3, 1'b0);

        // Watchdog: filter never finishes.
        never_done = 1'b1;
        d0 = done_cnt;
        pulse_start();
        send_samples(vecs[0], 1'b0, 1'b0, cyc);
        wait_idle("wd_idle");
        check("wd_error", 32'(error), 32'd1);
        check("wd_run_cycles", 32'(run_cycles), 32'(TO));
        check("wd_no_done", 32'(done_cnt - d0), 32'd0);
        check("wd_no_output", 32'(out_valid), 32'd0);
        never_done = 1'b0;
        run_job(0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of RUN.
        d0 = done_cnt;
        pulse_start();
        send_samples(vecs[1], 1'b0, 1'b0, cyc);
        cyc = 0;
        while (f_op != 2'b10 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("mid_in_run", 32'(f_op), 32'd2);
        reset = 1'b1;
        #1;
        check("mid_f_reset", 32'(f_reset), 32'd1);
        check("mid_f_op", 32'(f_op), 32'd0);
        tick();
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_f_reset_next", 32'(f_reset), 32'd1);
        check("mid_f_op_next", 32'(f_op), 32'd0);
        reset = 1'b0;
        repeat (2) tick();
        check("mid_no_done", 32'(done_cnt - d0), 32'd0);
        check("mid_idle", 32'(busy), 32'd0);
        run_job(2, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
